cpa_seq_resolve: RTL and testbench



---
 rtl/mult_pkg.sv | 18 +
 rtl/cpa_chunk_add.sv | 15 +
 rtl/cpa_seq_resolve.sv | 126 ++++++++++++
 tb/tb_cpa_seq_resolve.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared Wallace-tree multiplier definitions: default widths, CPA state type
// and the chunk-count helper reused by the other multiplier stages.
package mult_pkg;

  localparam int MULT_WIDTH = 64;
  localparam int CPA_CHUNK  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } cpa_state_t;

  function automatic int cpaNChunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/cpa_chunk_add.sv
// Combinational W-bit adder slice with carry-in/carry-out, time-multiplexed
// by cpa_seq_resolve across the operand chunks.
module cpa_chunk_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] s_o,
  output logic         co_o
);

  assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, ci_i};

endmodule

// File: rtl/cpa_seq_resolve.sv
// Resolves a carry-save (sum, carry) pair into one binary result using a
// chunked multi-cycle carry-propagate add; CPA_SINGLE_CYCLE_EN selects a one-cycle full-width add.
module cpa_seq_resolve
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CHUNK = CPA_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_s,
  input  logic [WIDTH-1:0] in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int NCHUNK = cpaNChunk(WIDTH, CHUNK);
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  cpa_state_t       state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             accept;

`ifndef CPA_SINGLE_CYCLE_EN
  logic [WIDTH-1:0] opS_q, opS_d;
  logic [WIDTH-1:0] opC_q, opC_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [CHUNK-1:0] chunkA, chunkB, chunkSum;
  logic             chunkCo;

  // One adder slice, steered by the chunk index, walks the operands LSB first.
  assign chunkA = opS_q[int'(idx_q)*CHUNK +: CHUNK];
  assign chunkB = opC_q[int'(idx_q)*CHUNK +: CHUNK];

  cpa_chunk_add #(.W(CHUNK)) u_chunk_add (
    .a_i  (chunkA),
    .b_i  (chunkB),
    .ci_i (carry_q),
    .s_o  (chunkSum),
    .co_o (chunkCo)
  );
`endif

  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    in_ready = 1'b0;
`ifndef CPA_SINGLE_CYCLE_EN
    opS_d    = opS_q;
    opC_d    = opC_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
`endif

    case (state_q)
      IDLE: in_ready = 1'b1;
`ifndef CPA_SINGLE_CYCLE_EN
      ADD: begin
        sum_d[int'(idx_q)*CHUNK +: CHUNK] = chunkSum;
        carry_d = chunkCo;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDXW'(NCHUNK - 1)) begin
          cout_d  = chunkCo;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        // Ready passes straight through so a waiting pair is taken with no idle gap.
        in_ready = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
`ifdef CPA_SINGLE_CYCLE_EN
      {cout_d, sum_d} = {1'b0, in_s} + {1'b0, in_c};
      state_d = DONE;
`else
      opS_d   = in_s;
      opC_d   = in_c;
      carry_d = 1'b0;
      idx_d   = '0;
      state_d = ADD;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifndef CPA_SINGLE_CYCLE_EN
      opS_q   <= '0;
      opC_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifndef CPA_SINGLE_CYCLE_EN
      opS_q   <= opS_d;
      opC_q   <= opC_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_cpa_seq_resolve.sv
// Directed bench for cpa_seq_resolve: hand-computed sums, latency, stall,
// back-to-back acceptance and mid-operation reset.
module tb_cpa_seq_resolve;

`ifdef CPA_SINGLE_CYCLE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 5;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_s;
  logic [63:0] in_c;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic        out_cout;

  int vectors     = 0;
  int miscompares = 0;

  cpa_seq_resolve dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: presents a pair, waits for acceptance, scrambles the
  // inputs and returns the number of cycles until out_valid.
  task automatic applyStimulus(input logic [63:0] s, input logic [63:0] c, output int lat);
    int guard;
    in_s = s;
    in_c = c;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("acceptReady", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_s = ~s;
    in_c = ~c;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [63:0] s;
    logic [63:0] c;
    logic [63:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[5] = '{
    '{64'h0000_0000_0000_0005, 64'h0000_0000_0000_0006, 64'h0000_0000_0000_000B, 1'b0},
    '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001, 1'b1},
    '{64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0002, 64'h0000_0000_0001_0001, 1'b0},
    '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1},
    '{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 64'h1234_5678_9ABC_DF00, 1'b0}
  };

  initial begin
    int lat;
    logic [63:0] heldSum;
    logic        heldCout;

    rst = 1'b1;
    in_valid = 1'b0;
    in_s = '0;
    in_c = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstValid", 64'(out_valid), 64'd0);
    checkOutput("rstReady", 64'(in_ready), 64'd1);
    checkOutput("rstSum", out_sum, 64'd0);
    checkOutput("rstCout", 64'(out_cout), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s, vecs[i].c, lat);
      checkOutput($sformatf("lat%0d", i), 64'(lat), 64'(LAT));
      checkOutput($sformatf("sum%0d", i), out_sum, vecs[i].sum);
      checkOutput($sformatf("cout%0d", i), 64'(out_cout), 64'(vecs[i].cout));
      @(negedge clk);
    end

    // Consumer stalls for 10 cycles, then releases while a new pair waits.
    out_ready = 1'b0;
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0002, lat);
    checkOutput("stallLat", 64'(lat), 64'(LAT));
    heldSum  = 64'h1;
    heldCout = 1'b1;
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("stallSum%0d", k), out_sum, heldSum);
      checkOutput($sformatf("stallCout%0d", k), 64'(out_cout), 64'(heldCout));
      checkOutput($sformatf("stallReady%0d", k), 64'(in_ready), 64'd0);
      checkOutput($sformatf("stallValid%0d", k), 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_s = 64'h0000_0000_0000_0005;
    in_c = 64'h0000_0000_0000_0006;
    in_valid = 1'b1;
    #1;
    checkOutput("b2bReady", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_s = '1;
    in_c = '1;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b2bLat", 64'(lat), 64'(LAT));
    checkOutput("b2bSum", out_sum, 64'h0000_0000_0000_000B);
    checkOutput("b2bCout", 64'(out_cout), 64'd0);
    @(negedge clk);

    // Reset two cycles after acceptance with the consumer stalled.
    out_ready = 1'b0;
    in_s = 64'hFFFF_FFFF_FFFF_FFFF;
    in_c = 64'h0000_0000_0000_0003;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midRstValid", 64'(out_valid), 64'd0);
    checkOutput("midRstSum", out_sum, 64'd0);
    checkOutput("midRstCout", 64'(out_cout), 64'd0);
    checkOutput("midRstReady", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("noStale%0d", k), 64'(out_valid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
